// File: rtl/cache_pkg.sv
// Shared definitions for the cache-side main-memory responder:
// request word layout, response width and controller state encoding.
package cache_pkg;

    localparam int REQ_WIDTH    = 25;
    localparam int RESP_WIDTH   = 16;
    localparam int REQ_WE_BIT   = 24;
    localparam int REQ_DATA_MSB = 23;
    localparam int REQ_DATA_LSB = 16;
    localparam int REQ_ADDR_MSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

endpackage

// File: rtl/byte_memory_array.sv
// Single-port byte array: synchronous byte write, combinational read of the
// aligned 16-bit word that contains the addressed byte.
module byte_memory_array #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [7:0]            i_wdata,
    output logic [15:0]           o_rdata
);

    logic [7:0]            r_mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] w_addr_even;
    logic [ADDR_WIDTH-1:0] w_addr_odd;

    assign w_addr_even = {i_addr[ADDR_WIDTH-1:1], 1'b0};
    assign w_addr_odd  = {i_addr[ADDR_WIDTH-1:1], 1'b1};

    // Contents are deliberately not reset; only the port logic is.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = {r_mem[w_addr_odd], r_mem[w_addr_even]};

endmodule

// File: rtl/cache_memory_controller.sv
// Two-port main-memory responder: round-robin arbitration between two caches,
// fixed-latency access to a byte array, held response until the cache drops its request.
module cache_memory_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REQ_WIDTH-1:0]  memory_request_0,
    input  logic [REQ_WIDTH-1:0]  memory_request_1,
    input  logic                  memory_request_ready_0,
    input  logic                  memory_request_ready_1,
    output logic [RESP_WIDTH-1:0] memory_response_0,
    output logic [RESP_WIDTH-1:0] memory_response_1,
    output logic                  memory_response_ready_0,
    output logic                  memory_response_ready_1
);

    state_t                r_state;
    state_t                w_state_next;
    logic [REQ_WIDTH-1:0]  r_req;
    logic [REQ_WIDTH-1:0]  w_req_next;
    logic                  r_chan;
    logic                  w_chan_next;
    logic                  r_last_grant;
    logic                  w_last_grant_next;
    logic [3:0]            r_count;
    logic [3:0]            w_count_next;
    logic [RESP_WIDTH-1:0] r_resp_0;
    logic [RESP_WIDTH-1:0] w_resp_0_next;
    logic [RESP_WIDTH-1:0] r_resp_1;
    logic [RESP_WIDTH-1:0] w_resp_1_next;
    logic                  r_rdy_0;
    logic                  w_rdy_0_next;
    logic                  r_rdy_1;
    logic                  w_rdy_1_next;

    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_wdata;
    logic [15:0]           w_rd_word;
    logic [15:0]           w_commit_word;
    logic                  w_granted_ready;

    assign w_addr  = r_req[ADDR_WIDTH-1:0];
    assign w_wdata = r_req[REQ_DATA_MSB:REQ_DATA_LSB];

    byte_memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clock   (clock),
        .i_we    (w_mem_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rd_word)
    );

    // The array read is pre-write at the commit edge, so merge the written byte
    // here to give the cache the post-write word.
    always_comb begin
        w_commit_word = w_rd_word;
        if (r_req[REQ_WE_BIT]) begin
            if (w_addr[0]) begin
                w_commit_word = {w_wdata, w_rd_word[7:0]};
            end else begin
                w_commit_word = {w_rd_word[15:8], w_wdata};
            end
        end
    end

    assign w_granted_ready = r_chan ? memory_request_ready_1 : memory_request_ready_0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_chan       <= 1'b0;
            r_last_grant <= 1'b1;
            r_count      <= '0;
            r_resp_0     <= '0;
            r_resp_1     <= '0;
            r_rdy_0      <= 1'b0;
            r_rdy_1      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_req        <= w_req_next;
            r_chan       <= w_chan_next;
            r_last_grant <= w_last_grant_next;
            r_count      <= w_count_next;
            r_resp_0     <= w_resp_0_next;
            r_resp_1     <= w_resp_1_next;
            r_rdy_0      <= w_rdy_0_next;
            r_rdy_1      <= w_rdy_1_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_req_next        = r_req;
        w_chan_next       = r_chan;
        w_last_grant_next = r_last_grant;
        w_count_next      = r_count;
        w_resp_0_next     = r_resp_0;
        w_resp_1_next     = r_resp_1;
        w_rdy_0_next      = r_rdy_0;
        w_rdy_1_next      = r_rdy_1;
        w_mem_we          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Channel 0 wins when alone or when channel 1 was served last.
                if (memory_request_ready_0 && (!memory_request_ready_1 || r_last_grant)) begin
                    w_req_next        = memory_request_0;
                    w_chan_next       = 1'b0;
                    w_last_grant_next = 1'b0;
                    w_count_next      = 4'(LATENCY - 1);
                    w_state_next      = ST_ACCESS;
                end else if (memory_request_ready_1) begin
                    w_req_next        = memory_request_1;
                    w_chan_next       = 1'b1;
                    w_last_grant_next = 1'b1;
                    w_count_next      = 4'(LATENCY - 1);
                    w_state_next      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_count == 4'd0) begin
                    w_mem_we = r_req[REQ_WE_BIT];
                    if (r_chan) begin
                        w_resp_1_next = w_commit_word;
                        w_rdy_1_next  = 1'b1;
                    end else begin
                        w_resp_0_next = w_commit_word;
                        w_rdy_0_next  = 1'b1;
                    end
                    w_state_next = ST_RESPOND;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            ST_RESPOND: begin
                if (!w_granted_ready) begin
                    w_resp_0_next = '0;
                    w_resp_1_next = '0;
                    w_rdy_0_next  = 1'b0;
                    w_rdy_1_next  = 1'b0;
                    w_state_next  = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign memory_response_0       = r_resp_0;
    assign memory_response_1       = r_resp_1;
    assign memory_response_ready_0 = r_rdy_0;
    assign memory_response_ready_1 = r_rdy_1;

endmodule

// File: tb/tb_cache_memory_controller.sv
// Scoreboard bench for cache_memory_controller: directed transactions push expected
// responses, a monitor pops them on each response-ready rise; extra builds check latency.
module tb_cache_memory_controller;

    localparam int L = 2;

    typedef struct {
        int          ch;
        logic [15:0] data;
        logic [15:0] mask;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [24:0] req0, req1;
    logic        rq_rdy0, rq_rdy1;
    logic [15:0] rsp0, rsp1;
    logic        rsp_rdy0, rsp_rdy1;

    logic [24:0] lat_req [2];
    logic        lat_rq_rdy [2];
    logic [15:0] lat_rsp0 [2];
    logic [15:0] lat_rsp1 [2];
    logic        lat_rsp_rdy0 [2];
    logic        lat_rsp_rdy1 [2];
    logic [24:0] lat_idle_req;
    logic        lat_idle_rdy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_drop0 = 0;
    int   t_rdy1 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;

    cache_memory_controller #(.ADDR_WIDTH(16), .LATENCY(L)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .memory_request_0        (req0),
        .memory_request_1        (req1),
        .memory_request_ready_0  (rq_rdy0),
        .memory_request_ready_1  (rq_rdy1),
        .memory_response_0       (rsp0),
        .memory_response_1       (rsp1),
        .memory_response_ready_0 (rsp_rdy0),
        .memory_response_ready_1 (rsp_rdy1)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_lat
        cache_memory_controller #(.ADDR_WIDTH(16), .LATENCY(gi == 0 ? 1 : 5)) u_lat (
            .clock                   (clock),
            .reset                   (reset),
            .memory_request_0        (lat_req[gi]),
            .memory_request_1        (lat_idle_req),
            .memory_request_ready_0  (lat_rq_rdy[gi]),
            .memory_request_ready_1  (lat_idle_rdy),
            .memory_response_0       (lat_rsp0[gi]),
            .memory_response_1       (lat_rsp1[gi]),
            .memory_response_ready_0 (lat_rsp_rdy0[gi]),
            .memory_response_ready_1 (lat_rsp_rdy1[gi])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Monitor: one scoreboard pop per rising response-ready, idle responses must read 0.
    always @(negedge clock) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                logic        r, p;
                logic [15:0] d;
                r = (c == 0) ? rsp_rdy0 : rsp_rdy1;
                p = (c == 0) ? prev0 : prev1;
                d = (c == 0) ? rsp0 : rsp1;
                if (r && !p) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL resp_unexpected ch%0d got %h with empty scoreboard", c, d);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.ch != c || (d & e.mask) !== (e.data & e.mask)) begin
                            errors++;
                            $display("FAIL resp ch%0d got %h, expected ch%0d %h (mask %h)",
                                     c, d, e.ch, e.data, e.mask);
                        end else begin
                            $display("txn ch%0d resp %h ok", c, d);
                        end
                    end
                end
                if (!r) begin
                    checks++;
                    if (d !== 16'h0000) begin
                        errors++;
                        $display("FAIL idle_resp ch%0d got %h, expected 0000", c, d);
                    end
                end
            end
        end
        prev0 = rsp_rdy0;
        prev1 = rsp_rdy1;
    end

    function automatic logic get_rdy(input int ch);
        return (ch == 0) ? rsp_rdy0 : rsp_rdy1;
    endfunction

    task automatic expect_resp(input int ch, input logic [15:0] d, input logic [15:0] m);
        exp_t e;
        e.ch = ch; e.data = d; e.mask = m;
        sb.push_back(e);
    endtask

    task automatic do_req(input int ch, input bit we, input logic [7:0] d,
                          input logic [15:0] a, input int hold, input int exp_lat);
        int n;
        bit seen;
        @(negedge clock);
        if (ch == 0) begin req0 = {we, d, a}; rq_rdy0 = 1'b1; end
        else         begin req1 = {we, d, a}; rq_rdy1 = 1'b1; end
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(negedge clock);
            n++;
            if (get_rdy(ch)) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout ch%0d addr %h no response within %0d cycles", ch, a, n);
        end else if (exp_lat >= 0) begin
            checks++;
            if (n - 1 != exp_lat) begin
                errors++;
                $display("FAIL latency ch%0d got %0d, expected %0d", ch, n - 1, exp_lat);
            end
        end
        if (ch == 1) t_rdy1 = cyc;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            checks++;
            if (!get_rdy(ch) || get_rdy(1 - ch)) begin
                errors++;
                $display("FAIL hold ch%0d cycle %0d own=%b other=%b, expected 1/0",
                         ch, h, get_rdy(ch), get_rdy(1 - ch));
            end
        end
        if (ch == 0) begin rq_rdy0 = 1'b0; t_drop0 = cyc; end
        else         rq_rdy1 = 1'b0;
        @(negedge clock);
        checks++;
        if (get_rdy(ch) !== 1'b0) begin
            errors++;
            $display("FAIL drop ch%0d ready=%b after request drop, expected 0", ch, get_rdy(ch));
        end
    endtask

    initial begin
        reset = 1'b0;
        req0 = '0; req1 = '0; rq_rdy0 = 1'b0; rq_rdy1 = 1'b0;
        lat_idle_req = '0; lat_idle_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin lat_req[i] = '0; lat_rq_rdy[i] = 1'b0; end
        repeat (3) @(negedge clock);
        checks++;
        if ({rsp0, rsp1, rsp_rdy0, rsp_rdy1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h %h %b %b, expected all 0", rsp0, rsp1, rsp_rdy0, rsp_rdy1);
        end
        reset = 1'b1;

        // Bring the addresses under test to a known zero state.
        expect_resp(0, 16'h0000, 16'hFF00); do_req(0, 1, 8'h00, 16'h0011, 0, L);
        expect_resp(0, 16'h0000, 16'hFFFF); do_req(0, 1, 8'h00, 16'h0010, 0, L);
        expect_resp(0, 16'h0000, 16'hFF00); do_req(0, 1, 8'h00, 16'h0017, 0, L);
        expect_resp(0, 16'h0000, 16'hFFFF); do_req(0, 1, 8'h00, 16'h0016, 0, L);
        expect_resp(0, 16'h0000, 16'hFF00); do_req(0, 1, 8'h00, 16'h0023, 0, L);
        expect_resp(0, 16'h0000, 16'hFFFF); do_req(0, 1, 8'h00, 16'h0022, 0, L);

        // Reset in the middle of an access discards the write.
        @(negedge clock);
        req0 = {1'b1, 8'hAA, 16'h0010};
        rq_rdy0 = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({rsp0, rsp1, rsp_rdy0, rsp_rdy1} !== '0) begin
            errors++;
            $display("FAIL async_reset got %h %h %b %b, expected all 0", rsp0, rsp1, rsp_rdy0, rsp_rdy1);
        end
        rq_rdy0 = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        expect_resp(0, 16'h0000, 16'hFFFF); do_req(0, 0, 8'h00, 16'h0010, 0, L);

        // Write-first response and aligned reads.
        expect_resp(0, 16'h1000, 16'hFFFF); do_req(0, 1, 8'd16, 16'h0017, 0, L);
        expect_resp(0, 16'h1000, 16'hFFFF); do_req(0, 0, 8'h00, 16'h0016, 0, L);
        expect_resp(1, 16'h1900, 16'hFFFF); do_req(1, 1, 8'd25, 16'h0017, 0, L);
        expect_resp(0, 16'h1900, 16'hFFFF); do_req(0, 0, 8'h00, 16'h0017, 0, L);
        expect_resp(1, 16'h1900, 16'hFFFF); do_req(1, 0, 8'h00, 16'h0016, 0, L);

        // Tie after a channel-1 grant: channel 0 first.
        expect_resp(0, 16'h00FF, 16'hFFFF);
        expect_resp(1, 16'h00FF, 16'hFFFF);
        fork
            do_req(0, 1, 8'hFF, 16'h0022, 0, L);
            do_req(1, 0, 8'h00, 16'h0022, 0, -1);
        join
        expect_resp(0, 16'h00FF, 16'hFFFF); do_req(0, 0, 8'h00, 16'h0023, 0, L);

        // Tie after a channel-0 grant: channel 1 first.
        expect_resp(1, 16'h00FF, 16'hFFFF);
        expect_resp(0, 16'h0011, 16'hFFFF);
        fork
            do_req(0, 1, 8'h11, 16'h0022, 0, -1);
            do_req(1, 0, 8'h00, 16'h0022, 0, L);
        join

        // Channel 0 holds its request; channel 1 waits until the drop.
        expect_resp(0, 16'h0011, 16'hFFFF);
        expect_resp(1, 16'h7711, 16'hFFFF);
        fork
            do_req(0, 0, 8'h00, 16'h0022, 10, L);
            begin
                @(negedge clock);
                do_req(1, 1, 8'h77, 16'h0023, 0, -1);
            end
        join
        checks++;
        if (t_rdy1 - t_drop0 != L + 2) begin
            errors++;
            $display("FAIL handoff cycles from drop to ch1 ready got %0d, expected %0d",
                     t_rdy1 - t_drop0, L + 2);
        end
        expect_resp(0, 16'h7711, 16'hFFFF); do_req(0, 0, 8'h00, 16'h0022, 0, L);

        // Latency builds 1 and 5.
        for (int i = 0; i < 2; i++) begin
            int n;
            int want;
            want = (i == 0) ? 1 : 5;
            @(negedge clock);
            lat_req[i] = {1'b1, 8'h5A, 16'h0001};
            lat_rq_rdy[i] = 1'b1;
            n = 0;
            while (!lat_rsp_rdy0[i] && n < 60) begin
                @(negedge clock);
                n++;
            end
            checks++;
            if (n - 1 != want || lat_rsp0[i][15:8] !== 8'h5A) begin
                errors++;
                $display("FAIL latency_build%0d got %0d cycles word %h, expected %0d cycles word 5Axx",
                         want, n - 1, lat_rsp0[i], want);
            end else begin
                $display("txn latency build %0d measured %0d", want, n - 1);
            end
            lat_rq_rdy[i] = 1'b0;
            repeat (2) @(negedge clock);
        end

        repeat (2) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
